// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// Master is the controller; slave is the datapath/memory side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output reg_write, illegal, state
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  reg_write, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multicycle RV32I core.
// Outputs decode from the state plus mem_ready/zero/funct3.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state_q;
    state_t state_d;

    logic is_ls;
    logic is_r;
    logic is_i;
    logic is_br;
    logic is_jal;
    logic br_ok;

    assign is_ls  = (bus.op == OP_LW) || (bus.op == OP_SW);
    assign is_r   = (bus.op == OP_R);
    assign is_i   = (bus.op == OP_I);
    assign is_br  = (bus.op == OP_BR);
    assign is_jal = (bus.op == OP_JAL);
    // Only beq (000) and bne (001) are implemented.
    assign br_ok  = (bus.funct3[2:1] == 2'b00);

    assign bus.state = state_q;

    // State register; reset lands in FETCH on the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state sequencing, waiting on mem_ready where memory is used.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_ls:   state_d = MEMADR;
                    is_r:    state_d = EXECR;
                    is_i:    state_d = EXECI;
                    is_br:   state_d = BRANCH;
                    is_jal:  state_d = JAL;
                    default: state_d = TRAP;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)      state_d = MEMREAD;
                else if (bus.op == OP_SW) state_d = MEMWRITE;
                else                      state_d = TRAP;
            end
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = br_ok ? FETCH : TRAP;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state datapath controls; reset forces every output low.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.illegal    = 1'b0;
        unique case (state_q)
            FETCH: begin
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            MEMREAD:  bus.adr_src = 1'b1;
            MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXECR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            ALUWB:    bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = br_ok & (bus.zero ^ bus.funct3[0]);
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
            end
            TRAP:     bus.illegal = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            bus.pc_write   = 1'b0;
            bus.adr_src    = 1'b0;
            bus.mem_write  = 1'b0;
            bus.ir_write   = 1'b0;
            bus.result_src = 2'b00;
            bus.alu_src_a  = 2'b00;
            bus.alu_src_b  = 2'b00;
            bus.alu_op     = 2'b00;
            bus.reg_write  = 1'b0;
            bus.illegal    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table
// plus a hand-driven lw sequence with variable memory waits.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [17:0] FULL   = 18'h3FFFF;
    localparam logic [17:0] RST_EN = 18'h02C03;
    localparam logic [17:0] RST_ST = 18'h3EC03;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        mr;
        logic [17:0] exp;
        logic [17:0] mask;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fails  = 0;

    // {state, pc_write, adr_src, mem_write, ir_write, result_src,
    //  alu_src_a, alu_src_b, alu_op, reg_write, illegal}
    function automatic logic [17:0] e(
        input logic [3:0] st, input logic pcw, input logic adr,
        input logic mw, input logic irw, input logic [1:0] rs,
        input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] aop, input logic rw, input logic ill);
        return {st, pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
    endfunction

    function automatic logic [17:0] x_fetch(input logic mr);
        return e(4'd0, mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    endfunction
    function automatic logic [17:0] x_branch(input logic pcw);
        return e(4'd9, pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    endfunction

    logic [17:0] X_DEC, X_MADR, X_MRD, X_MWB, X_MWR;
    logic [17:0] X_EXR, X_EXI, X_AWB, X_JAL, X_TRAP;

    task automatic add(input string nm, input logic r,
                       input logic [6:0] o, input logic [2:0] f,
                       input logic zz, input logic m,
                       input logic [17:0] x, input logic [17:0] k);
        vec_t v;
        v.name = nm; v.rst = r; v.op = o; v.f3 = f;
        v.z = zz; v.mr = m; v.exp = x; v.mask = k;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] actual();
        return {bus.state, bus.pc_write, bus.adr_src, bus.mem_write,
                bus.ir_write, bus.result_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.reg_write, bus.illegal};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.op = R; bus.funct3 = 3'b000;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        X_DEC  = e(4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
        X_MADR = e(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
        X_MRD  = e(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        X_MWB  = e(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
        X_MWR  = e(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        X_EXR  = e(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        X_EXI  = e(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
        X_AWB  = e(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        X_JAL  = e(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
        X_TRAP = e(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

        // reset then R-type
        add("rst_a", 0, R, 0, 0, 1, 18'h0, RST_EN);
        add("rst_b", 0, R, 0, 0, 1, 18'h0, RST_ST);
        add("r_fetch", 1, R, 0, 0, 1, x_fetch(1), FULL);
        add("r_dec", 1, R, 0, 0, 1, X_DEC, FULL);
        add("r_exec", 1, R, 0, 0, 1, X_EXR, FULL);
        add("r_wb", 1, R, 0, 0, 1, X_AWB, FULL);
        // lw with 2 fetch waits and 3 read waits
        add("lw_fw0", 1, LW, 0, 0, 0, x_fetch(0), FULL);
        add("lw_fw1", 1, LW, 0, 0, 0, x_fetch(0), FULL);
        add("lw_fetch", 1, LW, 0, 0, 1, x_fetch(1), FULL);
        add("lw_dec", 1, LW, 0, 0, 1, X_DEC, FULL);
        add("lw_adr", 1, LW, 0, 0, 1, X_MADR, FULL);
        add("lw_rw0", 1, LW, 0, 0, 0, X_MRD, FULL);
        add("lw_rw1", 1, LW, 0, 0, 0, X_MRD, FULL);
        add("lw_rw2", 1, LW, 0, 0, 0, X_MRD, FULL);
        add("lw_rd", 1, LW, 0, 0, 1, X_MRD, FULL);
        add("lw_wb", 1, LW, 0, 0, 1, X_MWB, FULL);
        // sw with one write wait
        add("sw_fetch", 1, SW, 0, 0, 1, x_fetch(1), FULL);
        add("sw_dec", 1, SW, 0, 0, 1, X_DEC, FULL);
        add("sw_adr", 1, SW, 0, 0, 1, X_MADR, FULL);
        add("sw_ww0", 1, SW, 0, 0, 0, X_MWR, FULL);
        add("sw_wr", 1, SW, 0, 0, 1, X_MWR, FULL);
        // I-ALU
        add("i_fetch", 1, IA, 0, 0, 1, x_fetch(1), FULL);
        add("i_dec", 1, IA, 0, 0, 1, X_DEC, FULL);
        add("i_exec", 1, IA, 0, 0, 1, X_EXI, FULL);
        add("i_wb", 1, IA, 0, 0, 1, X_AWB, FULL);
        // branches: beq/bne with zero 1 and 0
        add("beq1_f", 1, BR, 3'b000, 1, 1, x_fetch(1), FULL);
        add("beq1_d", 1, BR, 3'b000, 1, 1, X_DEC, FULL);
        add("beq1_b", 1, BR, 3'b000, 1, 1, x_branch(1), FULL);
        add("bne1_f", 1, BR, 3'b001, 1, 1, x_fetch(1), FULL);
        add("bne1_d", 1, BR, 3'b001, 1, 1, X_DEC, FULL);
        add("bne1_b", 1, BR, 3'b001, 1, 1, x_branch(0), FULL);
        add("beq0_f", 1, BR, 3'b000, 0, 1, x_fetch(1), FULL);
        add("beq0_d", 1, BR, 3'b000, 0, 1, X_DEC, FULL);
        add("beq0_b", 1, BR, 3'b000, 0, 1, x_branch(0), FULL);
        add("bne0_f", 1, BR, 3'b001, 0, 1, x_fetch(1), FULL);
        add("bne0_d", 1, BR, 3'b001, 0, 1, X_DEC, FULL);
        add("bne0_b", 1, BR, 3'b001, 0, 1, x_branch(1), FULL);
        // jal
        add("jal_f", 1, JL, 0, 0, 1, x_fetch(1), FULL);
        add("jal_d", 1, JL, 0, 0, 1, X_DEC, FULL);
        add("jal_j", 1, JL, 0, 0, 1, X_JAL, FULL);
        add("jal_wb", 1, JL, 0, 0, 1, X_AWB, FULL);
        // reset while MEMWRITE is waiting
        add("swr_f", 1, SW, 0, 0, 1, x_fetch(1), FULL);
        add("swr_d", 1, SW, 0, 0, 1, X_DEC, FULL);
        add("swr_a", 1, SW, 0, 0, 1, X_MADR, FULL);
        add("swr_w", 1, SW, 0, 0, 0, X_MWR, FULL);
        add("swr_rst", 0, SW, 0, 0, 0,
            e(4'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST_ST);
        add("swr_back", 1, SW, 0, 0, 0, x_fetch(0), FULL);
        add("swr_f2", 1, R, 0, 0, 1, x_fetch(1), FULL);
        add("swr_d2", 1, R, 0, 0, 1, X_DEC, FULL);
        add("swr_e2", 1, R, 0, 0, 1, X_EXR, FULL);
        add("swr_wb2", 1, R, 0, 0, 1, X_AWB, FULL);
        // bad funct3 on a branch traps without pc_write
        add("bbad_f", 1, BR, 3'b010, 1, 1, x_fetch(1), FULL);
        add("bbad_d", 1, BR, 3'b010, 1, 1, X_DEC, FULL);
        add("bbad_b", 1, BR, 3'b010, 1, 1, x_branch(0), FULL);
        add("bbad_t0", 1, BR, 3'b010, 1, 1, X_TRAP, FULL);
        add("bbad_t1", 1, R, 3'b000, 1, 1, X_TRAP, FULL);
        add("bbad_rst", 0, R, 0, 0, 1,
            e(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST_ST);
        // illegal opcode holds TRAP, then reset recovers
        add("ill_f", 1, BAD, 0, 0, 1, x_fetch(1), FULL);
        add("ill_d", 1, BAD, 0, 0, 1, X_DEC, FULL);
        for (int i = 0; i < 5; i++)
            add($sformatf("ill_t%0d", i), 1, BAD, 0, 1, 1, X_TRAP, FULL);
        add("ill_rst", 0, BAD, 0, 0, 1,
            e(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST_ST);
        add("ill_rec", 1, R, 0, 0, 0, x_fetch(0), FULL);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst;
            bus.op        = vecs[i].op;
            bus.funct3    = vecs[i].f3;
            bus.zero      = vecs[i].z;
            bus.mem_ready = vecs[i].mr;
            #1;
            check(vecs[i].name, 32'(actual() & vecs[i].mask),
                  32'(vecs[i].exp & vecs[i].mask));
        end

        // lw: 2 fetch waits, 3 read waits; count cycles and pulses
        begin
            int fw, rw, cyc, irw, wb_ok;
            bit done;
            fw = 0; rw = 0; cyc = 0; irw = 0; wb_ok = 0; done = 0;
            @(negedge clk);
            rst_n = 1'b0; bus.op = LW; bus.mem_ready = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 30 && !done; c++) begin
                if (c > 0) @(negedge clk);
                if (bus.state == 4'd0 && fw < 2) begin
                    bus.mem_ready = 1'b0; fw++;
                end else if (bus.state == 4'd3 && rw < 3) begin
                    bus.mem_ready = 1'b0; rw++;
                end else begin
                    bus.mem_ready = 1'b1;
                end
                #1;
                if (bus.state == 4'd0 && wb_ok != 0) begin
                    done = 1;
                end else begin
                    cyc++;
                    if (bus.ir_write) irw++;
                    if (bus.state == 4'd4 && bus.reg_write
                        && bus.result_src == 2'b01) wb_ok++;
                end
            end
            check("lw_seq_done", 32'(done), 32'd1);
            check("lw_seq_cycles", 32'(cyc), 32'd10);
            check("lw_seq_ir_pulses", 32'(irw), 32'd1);
            check("lw_seq_memwb", 32'(wb_ok), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and write enable for that step, including `alu_op`. The ALU decoder turns `alu_op` into the 4-bit ALU control. The block sits between the instruction register, the shared instruction/data memory port and the datapath muxes. It waits on a memory-ready handshake, so memory latency is variable.

## Interface
- No parameters. Opcode set and encodings are fixed as listed below.
- `clk` in 1: the single clock for the block, rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `zero` in 1: ALU zero flag, registered path.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: PC register load.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register and OldPC load.
- `result_src` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b` out 2: ALU B select. 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode by funct fields.
- `reg_write` out 1: register file write.
- `illegal` out 1: sticky flag for an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - branch 1100011 (beq/bne)
  - jal 1101111
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4
  - MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9
  - JAL 10, TRAP 11
- Unlisted outputs are 0 in every state. Selects not named in a state are don't-care, but the RTL drives them to 00.
- FETCH:
  - `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Go to DECODE when `mem_ready`=1; otherwise stay in FETCH.
- DECODE:
  - `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00. This computes the branch/jal target.
  - Next state by `op`: lw/sw → MEMADR, R → EXECR, I-ALU → EXECI, branch → BRANCH, jal → JAL, anything else → TRAP.
- MEMADR:
  - `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00.
  - lw → MEMREAD, sw → MEMWRITE.
- MEMREAD:
  - `result_src`=00, `adr_src`=1.
  - Stay until `mem_ready`, then go to MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, then FETCH.
- MEMWRITE:
  - `result_src`=00, `adr_src`=1, `mem_write`=1.
  - Hold until `mem_ready`, then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10, then ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, then ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, then FETCH.
- BRANCH:
  - `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`. funct3 000 is beq, 001 is bne.
  - Any other funct3 → TRAP, with no `pc_write`.
  - Valid funct3 → FETCH.
- JAL:
  - `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1.
  - Go to ALUWB, which writes PC+4 to rd.
- TRAP:
  - All enables 0, `illegal`=1.
  - Stays in TRAP until reset.

## Timing
- Clocking:
  - State register updates on the rising edge of `clk`.
  - All outputs decode combinationally from the state, plus `mem_ready`, `zero` and `funct3` where noted above.
- Reset:
  - While `rst_n`=0, every enable output is forced to 0, including `pc_write`, `ir_write`, `mem_write` and `reg_write`.
  - `illegal`=0 while `rst_n`=0.
  - The next state is FETCH, so `state`=0 after the first edge with `rst_n`=0.
- Reset mid-operation (for example during MEMWRITE waiting on `mem_ready`): the state returns to FETCH on the next edge and no write strobe appears in the reset cycle.
- Latency with `mem_ready` high, fetch included:
  - lw 5 cycles, sw 4, R/I 4, jal 4, branch 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. The outputs hold stable while waiting.
- `mem_write` stays asserted through every wait cycle of MEMWRITE and drops the cycle after `mem_ready`.
- `ir_write` and `pc_write` pulse exactly once per fetch, in the cycle where `mem_ready`=1.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles, then release with `op`=0110011, `mem_ready`=1.
  - Expect `state` sequence 0, 1, 6, 8, 0.
  - Expect `reg_write`=1 only in ALUWB, `alu_op`=10 in EXECR.
- **lw with wait states:** `mem_ready` low 2 cycles in FETCH and 3 cycles in MEMREAD.
  - Expect 10 cycles from FETCH entry back to FETCH.
  - Expect `ir_write` high for exactly 1 cycle.
  - Expect `result_src`=01 with `reg_write`=1 in MEMWB.
- **sw:** `mem_ready` low 1 cycle in MEMWRITE.
  - Expect `mem_write`=1 for 2 cycles with `adr_src`=1.
  - Expect no `reg_write`.
- **Branch:**
  - beq with `zero`=1 → `pc_write`=1 in BRANCH.
  - bne with `zero`=1 → `pc_write`=0.
  - funct3=010 → TRAP, `illegal`=1.
- **jal:**
  - Expect states 0, 1, 10, 8, 0.
  - Expect `pc_write`=1 in JAL, `alu_src_b`=10.
  - Expect `reg_write`=1 in ALUWB.
- **Illegal opcode and recovery:**
  - `op`=1111111 → TRAP holds for 5 cycles with all enables 0.
  - `rst_n` pulse → `illegal`=0, `state`=0.
